// File: rtl/pretrigger_sequencer.sv
// Pretrigger sequencer: turns a falling pretrigger edge into a delayed strobe,
// a gate of programmable width and a hold-off window, with event statistics.
module pretrigger_sequencer #(
  parameter int CNT_WIDTH  = 16,
  parameter int STAT_WIDTH = 16
) (
  input  logic                  evrClk,
  input  logic                  evrRst_n,
  input  logic                  evrPretrigger,
  input  logic                  cfgEnable,
  input  logic [CNT_WIDTH-1:0]  cfgDelay,
  input  logic [CNT_WIDTH-1:0]  cfgWidth,
  input  logic [CNT_WIDTH-1:0]  cfgHoldoff,
  input  logic                  statClear,
  output logic                  evrGateDriverStrobe,
  output logic                  evrGate,
  output logic                  busy,
  output logic [STAT_WIDTH-1:0] triggerCount,
  output logic [STAT_WIDTH-1:0] missedCount
);

  typedef enum logic [1:0] {IDLE, DELAY, GATE, HOLDOFF} state_t;

  localparam logic [CNT_WIDTH-1:0]  CNT_ONE  = 1;
  localparam logic [STAT_WIDTH-1:0] STAT_ONE = 1;

  state_t                 state;
  logic                   pretrig_d;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   lat_width;
  logic [CNT_WIDTH-1:0]   lat_holdoff;
  logic                   event_det;
  logic                   trig_inc;
  logic                   miss_inc;

  assign event_det = !evrPretrigger && pretrig_d;
  assign trig_inc  = event_det && (state == IDLE) && cfgEnable;
  assign miss_inc  = event_det && busy;

  // cnt is loaded straight from cfgDelay at the event, so it doubles as the
  // latched delay; every phase counts down to zero before moving on.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      state               <= IDLE;
      pretrig_d           <= 1'b0;
      cnt                 <= '0;
      lat_width           <= '0;
      lat_holdoff         <= '0;
      evrGateDriverStrobe <= 1'b0;
      evrGate             <= 1'b0;
      busy                <= 1'b0;
    end else begin
      pretrig_d           <= evrPretrigger;
      evrGateDriverStrobe <= 1'b0;
      if (state != IDLE && !cfgEnable) begin
        state   <= IDLE;
        evrGate <= 1'b0;
        busy    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (event_det && cfgEnable) begin
              state       <= DELAY;
              busy        <= 1'b1;
              cnt         <= cfgDelay;
              lat_width   <= cfgWidth;
              lat_holdoff <= cfgHoldoff;
            end
          end
          DELAY: begin
            if (cnt == '0) begin
              state               <= GATE;
              evrGateDriverStrobe <= 1'b1;
              evrGate             <= 1'b1;
              // a zero width still yields a one-cycle gate
              cnt                 <= (lat_width == '0) ? '0 : lat_width - CNT_ONE;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          GATE: begin
            if (cnt == '0) begin
              evrGate <= 1'b0;
              if (lat_holdoff == '0) begin
                state <= IDLE;
                busy  <= 1'b0;
              end else begin
                state <= HOLDOFF;
                cnt   <= lat_holdoff - CNT_ONE;
              end
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          HOLDOFF: begin
            if (cnt == '0) begin
              state <= IDLE;
              busy  <= 1'b0;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          default: begin
            state   <= IDLE;
            evrGate <= 1'b0;
            busy    <= 1'b0;
          end
        endcase
      end
    end
  end

  // Saturating statistics; a clear on the same edge overrides any increment.
  always_ff @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      triggerCount <= '0;
      missedCount  <= '0;
    end else if (statClear) begin
      triggerCount <= '0;
      missedCount  <= '0;
    end else begin
      if (trig_inc && triggerCount != '1) triggerCount <= triggerCount + STAT_ONE;
      if (miss_inc && missedCount != '1)  missedCount  <= missedCount + STAT_ONE;
    end
  end

endmodule

// File: tb/tb_pretrigger_sequencer.sv
// Bench for pretrigger_sequencer: directed scenarios plus random traffic,
// checked every cycle against a timeline model of the event schedule.
module tb_pretrigger_sequencer;

  localparam int CW   = 8;
  localparam int SW   = 4;
  localparam int SMAX = (1 << SW) - 1;

  logic          evrClk = 1'b0;
  logic          rst_n;
  logic          pin, en, clr;
  logic [CW-1:0] d, w, h;
  logic          strobe, gate, busy;
  logic [SW-1:0] tcnt, mcnt;

  int checks = 0;
  int errors = 0;

  // model: absolute edge times of the current/last sequence
  int t = 0;
  int sE = -100, sStr = -100, sGE = -100, sEnd = -100;
  int mtrig = 0, mmiss = 0;
  logic prev = 1'b0;

  pretrigger_sequencer #(.CNT_WIDTH(CW), .STAT_WIDTH(SW)) dut (
    .evrClk(evrClk), .evrRst_n(rst_n), .evrPretrigger(pin), .cfgEnable(en),
    .cfgDelay(d), .cfgWidth(w), .cfgHoldoff(h), .statClear(clr),
    .evrGateDriverStrobe(strobe), .evrGate(gate), .busy(busy),
    .triggerCount(tcnt), .missedCount(mcnt)
  );

  always #5 evrClk = ~evrClk;

  function automatic int satinc(input int x);
    return (x >= SMAX) ? SMAX : x + 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
    end
  endtask

  task automatic check_all();
    chk("strobe", {31'b0, strobe}, {31'b0, (t == sStr) && (t < sEnd)});
    chk("gate",   {31'b0, gate},   {31'b0, (t >= sStr) && (t < sGE) && (t < sEnd)});
    chk("busy",   {31'b0, busy},   {31'b0, (t >= sE) && (t < sEnd)});
    chk("trig",   32'(tcnt), 32'(mtrig));
    chk("miss",   32'(mcnt), 32'(mmiss));
  endtask

  // One clock edge: advance the model with the inputs present at the edge.
  task automatic step();
    logic bb, ev;
    @(posedge evrClk);
    t++;
    bb = (sE <= t - 1) && (t - 1 < sEnd);
    ev = !pin && prev;
    if (!en && bb) sEnd = t;
    if (ev && bb) mmiss = satinc(mmiss);
    else if (ev && en) begin
      sE   = t;
      sStr = t + 1 + int'(d);
      sGE  = sStr + ((w == '0) ? 1 : int'(w));
      sEnd = sGE + int'(h);
      mtrig = satinc(mtrig);
    end
    if (clr) begin mtrig = 0; mmiss = 0; end
    prev = pin;
    #1;
    check_all();
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic fire();
    pin = 1'b1; step();
    pin = 1'b0; step();
  endtask

  task automatic clear_stats();
    clr = 1'b1; step(); clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; pin = 1'b0; en = 1'b1; clr = 1'b0;
    d = '0; w = '0; h = '0;
    #1;
    chk("rst_strobe", {31'b0, strobe}, 32'd0);
    chk("rst_gate",   {31'b0, gate},   32'd0);
    chk("rst_busy",   {31'b0, busy},   32'd0);
    chk("rst_trig",   32'(tcnt), 32'd0);
    chk("rst_miss",   32'(mcnt), 32'd0);
    repeat (2) @(posedge evrClk);
    #3 rst_n = 1'b1;
    steps(2);

    // delay 10, width 5, holdoff 3
    d = 8'd10; w = 8'd5; h = 8'd3;
    fire();
    steps(25);
    chk("dw_trig", 32'(tcnt), 32'd1);

    // all-zero config
    d = '0; w = '0; h = '0;
    fire();
    steps(5);

    // three missed events during a long delay
    clear_stats();
    d = 8'd100; w = 8'd2; h = 8'd1;
    fire();
    repeat (3) fire();
    chk("miss3", 32'(mcnt), 32'd3);
    steps(110);

    // saturation of missed count, then clear against an increment
    d = 8'd255; w = 8'd1; h = 8'd0;
    fire();
    repeat (20) fire();
    chk("miss_sat", 32'(mcnt), 32'd15);
    pin = 1'b1; step();
    pin = 1'b0; clr = 1'b1; step(); clr = 1'b0;
    chk("clr_wins", 32'(mcnt), 32'd0);
    steps(260);

    // abort during the gate, then a full sequence
    d = 8'd2; w = 8'd8; h = 8'd3;
    fire();
    steps(4);
    en = 1'b0; step();
    chk("abort_gate", {31'b0, gate}, 32'd0);
    chk("abort_busy", {31'b0, busy}, 32'd0);
    steps(3);
    en = 1'b1; steps(2);
    fire();
    steps(18);

    // config changes after latching are ignored
    d = 8'd20; w = 8'd2; h = 8'd1;
    fire();
    steps(2);
    d = 8'd3;
    steps(25);
    fire();
    steps(10);

    // reset in the middle of a delay, pretrigger held low through release
    d = 8'd10; w = 8'd4; h = 8'd2;
    fire();
    steps(5);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_gate",   {31'b0, gate},   32'd0);
    chk("mid_rst_strobe", {31'b0, strobe}, 32'd0);
    chk("mid_rst_busy",   {31'b0, busy},   32'd0);
    chk("mid_rst_trig",   32'(tcnt), 32'd0);
    chk("mid_rst_miss",   32'(mcnt), 32'd0);
    sE = -100; sStr = -100; sGE = -100; sEnd = -100;
    mtrig = 0; mmiss = 0; prev = 1'b0;
    pin = 1'b0;
    repeat (2) @(posedge evrClk);
    #3 rst_n = 1'b1;
    steps(15);
    chk("no_evt_after_rst", 32'(tcnt), 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) pin = ~pin;
      en  = ($urandom_range(0, 59) != 0);
      clr = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 7) == 0) begin
        d = 8'($urandom_range(0, 6));
        w = 8'($urandom_range(0, 4));
        h = 8'($urandom_range(0, 3));
      end
      step();
    end
    clr = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pretrigger_sequencer.md
PRETRIGGER_SEQUENCER -- requirements
Module: pretrigger_sequencer

Interface
REQ-001 SHALL have parameter CNT_WIDTH, default 16: width of the delay, width and hold-off counters and config ports.
REQ-002 SHALL have parameter STAT_WIDTH, default 16: width of the status counters.
REQ-003 SHALL use one clock and an asynchronous, active-low reset.
REQ-004 Ports SHALL be:
- evrClk  in  1  event receiver clock; all logic on rising edge
- evrRst_n  in  1  asynchronous active-low reset
- evrPretrigger  in  1  pretrigger level, already in evrClk domain; falling edge = event
- cfgEnable  in  1  sequencer enable
- cfgDelay  in  CNT_WIDTH  cycles from event detect to strobe
- cfgWidth  in  CNT_WIDTH  gate width in cycles
- cfgHoldoff  in  CNT_WIDTH  dead time after gate in cycles
- statClear  in  1  one-cycle pulse that clears the status counters
- evrGateDriverStrobe  out  1  one-cycle strobe at gate start
- evrGate  out  1  gate level
- busy  out  1  high whenever state is not IDLE
- triggerCount  out  STAT_WIDTH  accepted events
- missedCount  out  STAT_WIDTH  events rejected while busy

Function
REQ-005 SHALL register evrPretrigger into pretrig_d; an event is detected at clock edge E when evrPretrigger=0 and pretrig_d=1 are sampled at E.
REQ-006 SHALL implement states IDLE, DELAY, GATE and HOLDOFF; busy SHALL be registered, equal to (state != IDLE).
REQ-007 IDLE: on an event with cfgEnable=1, SHALL latch cfgDelay, cfgWidth and cfgHoldoff, increment triggerCount, and enter DELAY at E.
REQ-008 IDLE: an event with cfgEnable=0 SHALL be ignored; neither counter changes.
REQ-009 evrGateDriverStrobe SHALL be high for exactly the one cycle after edge E+1+cfgDelay, where cfgDelay is the latched value; cfgDelay=0 gives a strobe in the cycle after E+1.
REQ-010 evrGate SHALL rise together with the strobe and stay high for exactly max(cfgWidth,1) cycles, while in state GATE.
REQ-011 After the gate, SHALL stay in HOLDOFF for cfgHoldoff cycles, then enter IDLE; cfgHoldoff=0 SHALL go directly from GATE to IDLE.
REQ-012 Config input changes after latching SHALL NOT affect the sequence in progress.
REQ-013 An event detected while busy=1 SHALL increment missedCount and SHALL NOT restart the sequence.
REQ-014 An event on the same edge that the FSM returns to IDLE SHALL count as missed.
REQ-015 Status counters SHALL saturate at all-ones and SHALL NOT wrap.
REQ-016 statClear SHALL zero both status counters; when it coincides with an increment, the clear wins and the result is 0.
REQ-017 cfgEnable=0 while busy SHALL abort to IDLE on the next edge; evrGate and the strobe SHALL be low from then on, and a strobe due on that edge SHALL be suppressed.
REQ-018 All outputs SHALL be registered, with no combinational path from input to output.
REQ-019 Down-counters SHALL be CNT_WIDTH bits wide; the maximum config value (all-ones) SHALL be supported without overflow.

Reset
REQ-020 While evrRst_n=0: state=IDLE, pretrig_d=0, evrGateDriverStrobe=0, evrGate=0, busy=0, triggerCount=0, missedCount=0, latched config=0.
REQ-021 Reset asserted mid-sequence SHALL force all outputs low asynchronously, with no strobe after release.
REQ-022 Because pretrig_d resets to 0, a pretrigger held low at reset release SHALL NOT produce an event.

Verification
REQ-023 Delay and width: cfgDelay=10, cfgWidth=5, cfgHoldoff=3, one falling edge detected at E -> strobe in the single cycle after E+11; gate high 5 cycles; busy drops 3 cycles after gate fall; triggerCount=1.
REQ-024 Zero config: cfgDelay=0, cfgWidth=0, cfgHoldoff=0 -> strobe in the cycle after E+1; gate high 1 cycle; IDLE in the next cycle.
REQ-025 Missed events and saturation: 3 falling edges during a cfgDelay=100 sequence -> missedCount=3 and one strobe only; with STAT_WIDTH=4 and 20 missed events -> missedCount=15; statClear on an increment edge -> 0.
REQ-026 Abort: cfgEnable dropped while in GATE, cycle 2 of cfgWidth=8 -> gate low on the next edge, busy=0, no further strobe; a new edge then starts a full sequence.
REQ-027 Config stability: cfgDelay changed from 20 to 3 at E+2 -> strobe still after E+21; the next event uses 3.
REQ-028 Reset: evrRst_n pulsed low at E+5 during cfgDelay=10 -> outputs low immediately; counters 0; no strobe; pretrigger held low through release gives no event.
